// File: rtl/capture_buffer.sv
// Trigger-driven frame capture: waits for a level crossing (or timeout) on a signed
// sample stream, records DEPTH consecutive samples, then holds the frame until acknowledged.
module capture_buffer #(
    parameter int WIDTH   = 12,
    parameter int DEPTH   = 512,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    input  logic             arm,
    input  logic [WIDTH-1:0] trig_level,
    input  logic             trig_edge,
    input  logic             auto_trig,
    input  logic             frame_ack,
    output logic [WIDTH-1:0] data [0:DEPTH-1],
    output logic             frame_ready,
    output logic             busy,
    output logic             auto_fired
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FILL,
        READY
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   wrPtr_q;
    logic [PTR_W-1:0]   wrPtr_d;
    logic [CNT_W-1:0]   toCnt_q;
    logic [CNT_W-1:0]   toCnt_d;
    logic [WIDTH-1:0]   prev_q;
    logic               prevValid_q;
    logic [WIDTH-1:0]   data_q [0:DEPTH-1];
    logic               frameReady_q;
    logic               busy_q;
    logic               autoFired_q;

    logic               riseHit;
    logic               fallHit;
    logic               crossHit;
    logic               timeoutHit;
    logic               lastWrite;

    // Crossings need a previous sample from the current arming, so the first one never triggers.
    assign riseHit  = prevValid_q
                    && ($signed(prev_q) < $signed(trig_level))
                    && ($signed(sample_in) >= $signed(trig_level));
    assign fallHit  = prevValid_q
                    && ($signed(prev_q) > $signed(trig_level))
                    && ($signed(sample_in) <= $signed(trig_level));
    assign crossHit = trig_edge ? fallHit : riseHit;

    assign toCnt_d    = toCnt_q + 1'b1;
    assign timeoutHit = auto_trig && (toCnt_q == CNT_W'(TIMEOUT - 1));

    assign lastWrite = (wrPtr_q == PTR_W'(DEPTH - 1));
    assign wrPtr_d   = lastWrite ? '0 : wrPtr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wrPtr_q      <= '0;
            toCnt_q      <= '0;
            prev_q       <= '0;
            prevValid_q  <= 1'b0;
            frameReady_q <= 1'b0;
            busy_q       <= 1'b0;
            autoFired_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    toCnt_q     <= '0;
                    prevValid_q <= 1'b0;
                    if (arm) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end

                ARM: begin
                    if (sample_valid) begin
                        prev_q      <= sample_in;
                        prevValid_q <= 1'b1;
                        // A crossing takes priority over a timeout landing on the same sample.
                        if (crossHit) begin
                            data_q[0]   <= sample_in;
                            wrPtr_q     <= PTR_W'(1);
                            autoFired_q <= 1'b0;
                            state_q     <= FILL;
                        end else if (auto_trig) begin
                            toCnt_q <= toCnt_d;
                            if (timeoutHit) begin
                                data_q[0]   <= sample_in;
                                wrPtr_q     <= PTR_W'(1);
                                autoFired_q <= 1'b1;
                                state_q     <= FILL;
                            end
                        end
                    end
                end

                FILL: begin
                    if (sample_valid) begin
                        data_q[wrPtr_q] <= sample_in;
                        wrPtr_q         <= wrPtr_d;
                        if (lastWrite) begin
                            state_q      <= READY;
                            frameReady_q <= 1'b1;
                            busy_q       <= 1'b0;
                        end
                    end
                end

                READY: begin
                    if (frame_ack) begin
                        state_q      <= IDLE;
                        frameReady_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data        = data_q;
    assign frame_ready = frameReady_q;
    assign busy        = busy_q;
    assign auto_fired  = autoFired_q;

endmodule
